count_tick_ctrl: RTL

//   Upstream control stage for the 3-bit counter in top. Generates the counter's
//   one-cycle count-enable pulse (tick) from a prescaler while RUNNING, or one pulse
//   per STEP button press while PAUSED. Debounces two raw board buttons and keeps the
//   run/pause state. Clocked by the 100 MHz board clock.

---
 rtl/count_tick_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/count_tick_ctrl.sv
// rtl/count_tick_ctrl.sv - tick generator for the 3-bit counter: prescaler, step button, run/pause
// Both buttons are synchronized and debounced; the run button toggles RUNNING/PAUSED.
module count_tick_ctrl #(
  parameter int DIV       = 100_000_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_step,
  output logic tick,
  output logic running
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (DB_CYCLES > 0) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  // Bit 0 carries the run button, bit 1 the step button.
  logic [1:0]    btn_raw;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    db_state_q, db_state_d;
  logic [1:0]    db_prev_q, db_prev_d;
  logic [CW-1:0] db_cnt_q [2];
  logic [CW-1:0] db_cnt_d [2];
  logic [1:0]    press;
  logic          run_press, step_press;

  state_t        state_q, state_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          tick_q, tick_d;

  assign btn_raw = {btn_step, btn_run};

  always_comb begin
    sync1_d   = btn_raw;
    sync2_d   = sync1_q;
    db_prev_d = db_state_q;
  end

  // A change is accepted only after DB_CYCLES consecutive differing samples.
  always_comb begin
    db_state_d = db_state_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_state_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_state_d[i] = ~db_state_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign press      = db_state_q & ~db_prev_q;
  assign run_press  = press[0];
  assign step_press = press[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_state_q  <= '0;
      db_prev_q   <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      state_q     <= PAUSED;
      div_cnt_q   <= '0;
      tick_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      db_state_q  <= db_state_d;
      db_prev_q   <= db_prev_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      tick_q      <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (run_press) begin
      state_d = (state_q == PAUSED) ? RUNNING : PAUSED;
    end
  end

  // A run press takes priority over both a pending step and a due prescaler tick.
  always_comb begin
    div_cnt_d = div_cnt_q;
    tick_d    = 1'b0;
    case (state_q)
      PAUSED: begin
        if (run_press) begin
          div_cnt_d = '0;
        end else if (step_press) begin
          tick_d = 1'b1;
        end
      end
      RUNNING: begin
        if (run_press) begin
          div_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          tick_d    = 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      default: begin
        div_cnt_d = '0;
      end
    endcase
  end

  assign tick    = tick_q;
  assign running = (state_q == RUNNING);

endmodule
